btn_debounce: RTL and testbench

Debounces and synchronises the four Nexys A7 push-buttons before they reach the `nnRvSoc` button input, directly upstream of the SoC's `{BTND, BTNU, BTNR, BTNL}` port. It runs in the SoC clock domain (`CLK`, about 195 kHz). It produces three outputs per button:
- a clean level,
- a one-cycle press pulse,
- a sticky event flag, held until the CPU acknowledges it.

---
 rtl/btn_debounce_if.sv | 45 ++++
 rtl/btn_debounce.sv | 198 +++++++++++++++++++
 tb/tb_btn_debounce.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_if.sv
// -----------------------------------------------------------------------------
// btn_debounce_if
//   Signal bundle between the raw push-button pads / CPU event logic and the
//   btn_debounce block.
//
//   Signals (all NUM_BTN wide unless noted), bit order {BTND, BTNU, BTNR, BTNL}:
//     BTN_IN    raw asynchronous pad levels
//     EVT_ACK   per-bit clear of the sticky event flags
//     BTN_LVL   debounced level
//     BTN_PRESS one-cycle pulse per accepted press (and per auto-repeat)
//     BTN_EVT   sticky press flags
//     EVT_ANY   1 bit, OR of BTN_EVT (registered)
//
//   Modports:
//     master - pad / CPU side: drives BTN_IN and EVT_ACK
//     slave  - debouncer side: drives the level, pulse and event outputs
// -----------------------------------------------------------------------------
interface btn_debounce_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] BTN_IN;
    logic [NUM_BTN-1:0] EVT_ACK;
    logic [NUM_BTN-1:0] BTN_LVL;
    logic [NUM_BTN-1:0] BTN_PRESS;
    logic [NUM_BTN-1:0] BTN_EVT;
    logic               EVT_ANY;

    modport master (
        output BTN_IN,
        output EVT_ACK,
        input  BTN_LVL,
        input  BTN_PRESS,
        input  BTN_EVT,
        input  EVT_ANY
    );

    modport slave (
        input  BTN_IN,
        input  EVT_ACK,
        output BTN_LVL,
        output BTN_PRESS,
        output BTN_EVT,
        output EVT_ANY
    );
endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Synchronises and debounces NUM_BTN push-buttons in the SoC clock domain.
//   Per button it produces a clean level, a one-cycle press pulse and a sticky
//   event flag that stays set until the CPU acknowledges it.
//
//   Ports:
//     CLK  in   single clock (SoC clock, ~195 kHz)
//     RST  in   synchronous active-high reset
//     bus  slave modport of btn_debounce_if:
//            BTN_IN (in), EVT_ACK (in), BTN_LVL, BTN_PRESS, BTN_EVT, EVT_ANY (out)
//
//   Optional feature macro: BTN_AUTOREPEAT_EN
//     defined   - a held button emits extra BTN_PRESS pulses REPEAT_DELAY
//                 cycles after the press, then every REPEAT_PERIOD cycles.
//     undefined - exactly one pulse per debounced press; REPEAT_* unused.
//
//   Each button runs its own FSM:
//     RELEASED -> PRESS_WAIT -> HELD -> REL_WAIT -> RELEASED
//   A level change is accepted once s2 has shown the new value on
//   DEBOUNCE_CYCLES+1 consecutive edges, giving DEBOUNCE_CYCLES+3 edges of
//   latency from the pad including the 2-flop synchroniser.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 2048,
    parameter int CNT_W           = 12,
    parameter int REPEAT_DELAY    = 4095,
    parameter int REPEAT_PERIOD   = 1024
) (
    input  logic          CLK,
    input  logic          RST,
    btn_debounce_if.slave bus
);

    // Configurations whose compare values do not fit the counter are rejected
    // at elaboration rather than silently truncated.
    if ((DEBOUNCE_CYCLES < 2) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1) ||
        ((1 << CNT_W) < DEBOUNCE_CYCLES) ||
        ((1 << CNT_W) < REPEAT_DELAY) ||
        ((1 << CNT_W) < REPEAT_PERIOD)) begin : g_bad_cfg
        $error("btn_debounce: illegal DEBOUNCE_CYCLES / REPEAT_* / CNT_W combination");
    end

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    logic [NUM_BTN-1:0] s1_reg;
    logic [NUM_BTN-1:0] s2_reg;
    logic [NUM_BTN-1:0] press_fire;   // a pulse is being produced on this edge
    logic [NUM_BTN-1:0] lvl_vec;
    logic [NUM_BTN-1:0] press_vec;
    logic [NUM_BTN-1:0] evt_reg;
    logic [NUM_BTN-1:0] evt_next;
    logic               evt_any_reg;

    // Two-flop synchroniser for the asynchronous pads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= bus.BTN_IN;
            s2_reg <= s1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            state_t           state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             lvl_reg;
            logic             press_reg;
            logic             deb_fire;

            // Debounce accepted on this edge: last counted cycle with s2 still high.
            assign deb_fire = (state_reg == PRESS_WAIT) && s2_reg[gi] &&
                              (cnt_reg == DEB_LAST);

`ifdef BTN_AUTOREPEAT_EN
            logic [CNT_W-1:0] rpt_reg;
            logic             rpt_phase_reg;   // 0: waiting for first repeat, 1: periodic
            logic [CNT_W-1:0] rpt_last;
            logic             rpt_fire;

            always_comb begin
                rpt_last = rpt_phase_reg ? RPT_PERIOD_LAST : RPT_DELAY_LAST;
            end

            // Repeats only fire while the button is settled in HELD and stays
            // high; during REL_WAIT the timer saturates so a quickly recovered
            // glitch fires the overdue repeat on return to HELD.
            assign rpt_fire = (state_reg == HELD) && s2_reg[gi] &&
                              (rpt_reg == rpt_last);
            assign press_fire[gi] = deb_fire | rpt_fire;
`else
            assign press_fire[gi] = deb_fire;
`endif

            always_ff @(posedge CLK) begin
                if (RST) begin
                    state_reg <= RELEASED;
                    cnt_reg   <= '0;
                    lvl_reg   <= 1'b0;
                    press_reg <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                    rpt_reg       <= '0;
                    rpt_phase_reg <= 1'b0;
`endif
                end else begin
                    press_reg <= press_fire[gi];
                    case (state_reg)
                        RELEASED: begin
                            if (s2_reg[gi]) begin
                                state_reg <= PRESS_WAIT;
                                cnt_reg   <= '0;
                            end
                        end
                        PRESS_WAIT: begin
                            if (!s2_reg[gi]) begin
                                state_reg <= RELEASED;
                            end else if (cnt_reg == DEB_LAST) begin
                                state_reg <= HELD;
                                lvl_reg   <= 1'b1;
                            end else begin
                                cnt_reg <= cnt_reg + 1'b1;
                            end
                        end
                        HELD: begin
                            if (!s2_reg[gi]) begin
                                state_reg <= REL_WAIT;
                                cnt_reg   <= '0;
                            end
                        end
                        REL_WAIT: begin
                            if (s2_reg[gi]) begin
                                state_reg <= HELD;
                            end else if (cnt_reg == DEB_LAST) begin
                                state_reg <= RELEASED;
                                lvl_reg   <= 1'b0;
                            end else begin
                                cnt_reg <= cnt_reg + 1'b1;
                            end
                        end
                        default: begin
                            state_reg <= RELEASED;
                        end
                    endcase
`ifdef BTN_AUTOREPEAT_EN
                    if (deb_fire) begin
                        rpt_reg       <= '0;
                        rpt_phase_reg <= 1'b0;
                    end else if ((state_reg == HELD) || (state_reg == REL_WAIT)) begin
                        if (rpt_fire) begin
                            rpt_reg       <= '0;
                            rpt_phase_reg <= 1'b1;
                        end else if (rpt_reg != rpt_last) begin
                            rpt_reg <= rpt_reg + 1'b1;
                        end
                    end
`endif
                end
            end

            assign lvl_vec[gi]   = lvl_reg;
            assign press_vec[gi] = press_reg;
        end
    endgenerate

    // Set has priority over ack, so a press coinciding with an ack is not lost.
    assign evt_next = press_fire | (evt_reg & ~bus.EVT_ACK);

    always_ff @(posedge CLK) begin
        if (RST) begin
            evt_reg     <= '0;
            evt_any_reg <= 1'b0;
        end else begin
            evt_reg     <= evt_next;
            evt_any_reg <= |evt_next;
        end
    end

    assign bus.BTN_LVL   = lvl_vec;
    assign bus.BTN_PRESS = press_vec;
    assign bus.BTN_EVT   = evt_reg;
    assign bus.EVT_ANY   = evt_any_reg;

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//   Directed scenarios with edge-exact expectations plus a randomized run
//   compared against a run-length reference model of the debouncer.
//   Honours BTN_AUTOREPEAT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

    localparam int NB  = 4;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    btn_debounce_if #(.NUM_BTN(NB)) bus_if ();

    btn_debounce #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (4),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A level flips once s2 has differed from it on DEB+1 consecutive edges.
    // Repeats are scheduled by absolute edge index ("due").
    logic [NB-1:0] m_s1, m_s2, m_lvl, m_press, m_evt, m_prs;
    logic          m_any;
    int            m_run [NB];
    int            m_due [NB];
    int            m_now;
    logic          m_held;

    initial m_now = 0;

    always @(posedge clk) begin
        m_prs = '0;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_evt = '0;
            for (int i = 0; i < NB; i++) begin
                m_run[i] = 0;
                m_due[i] = 0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                m_held = m_lvl[i] && (m_run[i] == 0);
                if (m_s2[i] != m_lvl[i]) m_run[i] = m_run[i] + 1;
                else                     m_run[i] = 0;
                if (m_run[i] == DEB + 1) begin
                    m_lvl[i] = m_s2[i];
                    m_run[i] = 0;
                    if (m_s2[i]) begin
                        m_prs[i] = 1'b1;
                        m_due[i] = m_now + RD;
                    end
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (m_held && m_s2[i] && (m_now >= m_due[i])) begin
                    m_prs[i] = 1'b1;
                    m_due[i] = m_now + RP;
                end
`endif
            end
            m_s2  = m_s1;
            m_s1  = bus_if.BTN_IN;
            m_evt = m_prs | (m_evt & ~bus_if.EVT_ACK);
        end
        m_press = m_prs;
        m_any   = |m_evt;
        m_now   = m_now + 1;
    end

    // ---------------- scenarios ----------------
    task automatic release_all();
        bus_if.BTN_IN = '0;
        repeat (14) @(negedge clk);
        bus_if.EVT_ACK = '1;
        @(negedge clk);
        bus_if.EVT_ACK = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.BTN_IN  = '0;
        bus_if.EVT_ACK = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus_if.BTN_LVL !== 4'b0)   begin errors++; $display("FAIL reset_lvl: got %b expected 0000", bus_if.BTN_LVL); end
        checks++; if (bus_if.BTN_PRESS !== 4'b0) begin errors++; $display("FAIL reset_press: got %b expected 0000", bus_if.BTN_PRESS); end
        checks++; if (bus_if.BTN_EVT !== 4'b0)   begin errors++; $display("FAIL reset_evt: got %b expected 0000", bus_if.BTN_EVT); end
        checks++; if (bus_if.EVT_ANY !== 1'b0)   begin errors++; $display("FAIL reset_any: got %b expected 0", bus_if.EVT_ANY); end
        rst = 1'b0;
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_clean_press();
        logic e_b;
        bus_if.BTN_IN = 4'b0001;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            e_b = (e >= 7);
            checks++; if (bus_if.BTN_LVL[0] !== e_b) begin errors++; $display("FAIL clean_lvl edge %0d: got %b expected %b", e, bus_if.BTN_LVL[0], e_b); end
            checks++; if (bus_if.BTN_PRESS !== ((e == 7) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL clean_press edge %0d: got %b expected %b", e, bus_if.BTN_PRESS, (e == 7) ? 4'b0001 : 4'b0000); end
            checks++; if (bus_if.BTN_EVT[0] !== e_b) begin errors++; $display("FAIL clean_evt edge %0d: got %b expected %b", e, bus_if.BTN_EVT[0], e_b); end
            checks++; if (bus_if.EVT_ANY !== e_b) begin errors++; $display("FAIL clean_any edge %0d: got %b expected %b", e, bus_if.EVT_ANY, e_b); end
        end
        release_all();
        checks++; if (bus_if.BTN_EVT !== 4'b0 || bus_if.EVT_ANY !== 1'b0) begin errors++; $display("FAIL clean_ack: got evt=%b any=%b expected 0000/0", bus_if.BTN_EVT, bus_if.EVT_ANY); end
        $display("test_clean_press: BTN_IN=0001 held, press on edge 7");
    endtask

    task automatic test_bounce();
        logic e_b;
        for (int k = 0; k < 4; k++) begin
            bus_if.BTN_IN[1] = (k % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                checks++; if (bus_if.BTN_PRESS[1] !== 1'b0 || bus_if.BTN_LVL[1] !== 1'b0) begin errors++; $display("FAIL bounce_quiet: got press=%b lvl=%b expected 0/0", bus_if.BTN_PRESS[1], bus_if.BTN_LVL[1]); end
            end
        end
        bus_if.BTN_IN[1] = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            e_b = (e == 7);
            checks++; if (bus_if.BTN_PRESS[1] !== e_b) begin errors++; $display("FAIL bounce_press edge %0d: got %b expected %b", e, bus_if.BTN_PRESS[1], e_b); end
            e_b = (e >= 7);
            checks++; if (bus_if.BTN_LVL[1] !== e_b) begin errors++; $display("FAIL bounce_lvl edge %0d: got %b expected %b", e, bus_if.BTN_LVL[1], e_b); end
        end
        release_all();
        $display("test_bounce: 1,0,1,0 bounce then hold on BTN_IN[1]");
    endtask

    task automatic test_release();
        logic e_b;
        bus_if.BTN_IN = 4'b0100;
        repeat (7) @(negedge clk);
        checks++; if (bus_if.BTN_LVL[2] !== 1'b1 || bus_if.BTN_PRESS[2] !== 1'b1) begin errors++; $display("FAIL release_press: got lvl=%b press=%b expected 1/1", bus_if.BTN_LVL[2], bus_if.BTN_PRESS[2]); end
        bus_if.BTN_IN[2] = 1'b0;        // 2-cycle low glitch
        for (int e = 8; e <= 12; e++) begin
            @(negedge clk);
            if (e == 9) bus_if.BTN_IN[2] = 1'b1;
            checks++; if (bus_if.BTN_LVL[2] !== 1'b1 || bus_if.BTN_PRESS[2] !== 1'b0) begin errors++; $display("FAIL release_glitch edge %0d: got lvl=%b press=%b expected 1/0", e, bus_if.BTN_LVL[2], bus_if.BTN_PRESS[2]); end
        end
        bus_if.BTN_IN[2] = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            e_b = (e < 7);
            checks++; if (bus_if.BTN_LVL[2] !== e_b) begin errors++; $display("FAIL release_lvl edge %0d: got %b expected %b", e, bus_if.BTN_LVL[2], e_b); end
            checks++; if (bus_if.BTN_PRESS !== 4'b0) begin errors++; $display("FAIL release_nopulse edge %0d: got %b expected 0000", e, bus_if.BTN_PRESS); end
        end
        release_all();
        $display("test_release: glitch ignored, BTN_LVL[2] fell on edge 7");
    endtask

    task automatic test_ack_race();
        bus_if.BTN_IN = 4'b0001;
        repeat (6) @(negedge clk);
        bus_if.EVT_ACK = 4'b0001;       // sampled on the same edge as the press
        @(negedge clk);
        checks++; if (bus_if.BTN_PRESS[0] !== 1'b1) begin errors++; $display("FAIL ackrace_press: got %b expected 1", bus_if.BTN_PRESS[0]); end
        checks++; if (bus_if.BTN_EVT[0] !== 1'b1 || bus_if.EVT_ANY !== 1'b1) begin errors++; $display("FAIL ackrace_setwins: got evt=%b any=%b expected 1/1", bus_if.BTN_EVT[0], bus_if.EVT_ANY); end
        @(negedge clk);
        checks++; if (bus_if.BTN_EVT[0] !== 1'b0 || bus_if.EVT_ANY !== 1'b0) begin errors++; $display("FAIL ackrace_clear: got evt=%b any=%b expected 0/0", bus_if.BTN_EVT[0], bus_if.EVT_ANY); end
        bus_if.EVT_ACK = 4'b0000;
        release_all();
        $display("test_ack_race: ack with press keeps flag, next ack clears");
    endtask

    task automatic test_reset_mid();
        logic e_b;
        bus_if.BTN_IN = 4'b0001;
        repeat (5) @(negedge clk);      // PRESS_WAIT with cnt = 2
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({bus_if.BTN_LVL, bus_if.BTN_PRESS, bus_if.BTN_EVT, bus_if.EVT_ANY} !== 13'b0) begin errors++; $display("FAIL resetmid_zero: got lvl=%b press=%b evt=%b any=%b expected all 0", bus_if.BTN_LVL, bus_if.BTN_PRESS, bus_if.BTN_EVT, bus_if.EVT_ANY); end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            e_b = (e == 7);
            checks++; if (bus_if.BTN_PRESS[0] !== e_b) begin errors++; $display("FAIL resetmid_press edge %0d: got %b expected %b", e, bus_if.BTN_PRESS[0], e_b); end
            e_b = (e >= 7);
            checks++; if (bus_if.BTN_LVL[0] !== e_b) begin errors++; $display("FAIL resetmid_lvl edge %0d: got %b expected %b", e, bus_if.BTN_LVL[0], e_b); end
        end
        release_all();
        $display("test_reset_mid: reset in PRESS_WAIT, press re-accepted on edge 7");
    endtask

    task automatic test_autorepeat();
        logic e_b;
        bus_if.BTN_IN = 4'b1000;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
`ifdef BTN_AUTOREPEAT_EN
            e_b = (e == 7) || (e == 17) || (e == 22) || (e == 27) || (e == 32);
`else
            e_b = (e == 7);
`endif
            checks++; if (bus_if.BTN_PRESS[3] !== e_b) begin errors++; $display("FAIL autorepeat_press edge %0d: got %b expected %b", e, bus_if.BTN_PRESS[3], e_b); end
            if (e == 30) bus_if.BTN_IN = 4'b0000;
        end
        release_all();
        $display("test_autorepeat: BTN_IN[3] held 30 cycles");
    endtask

    task automatic test_random();
        int hold [NB];
        int seg_err;
        rst = 1'b1;
        bus_if.BTN_IN  = '0;
        bus_if.EVT_ACK = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NB; i++) hold[i] = 0;
        for (int seg = 0; seg < 20; seg++) begin
            seg_err = errors;
            for (int c = 0; c < 100; c++) begin
                for (int i = 0; i < NB; i++) begin
                    if (hold[i] == 0) begin
                        bus_if.BTN_IN[i] = ~bus_if.BTN_IN[i];
                        hold[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 25));
                    end else begin
                        hold[i] = hold[i] - 1;
                    end
                end
                bus_if.EVT_ACK = 4'($urandom) & 4'($urandom) & 4'($urandom);
                rst = ($urandom_range(0, 399) == 0);
                @(negedge clk);
                checks++;
                if ({bus_if.BTN_LVL, bus_if.BTN_PRESS, bus_if.BTN_EVT, bus_if.EVT_ANY} !== {m_lvl, m_press, m_evt, m_any}) begin
                    errors++;
                    $display("FAIL random seg %0d cyc %0d: got lvl=%b press=%b evt=%b any=%b expected lvl=%b press=%b evt=%b any=%b",
                             seg, c, bus_if.BTN_LVL, bus_if.BTN_PRESS, bus_if.BTN_EVT, bus_if.EVT_ANY, m_lvl, m_press, m_evt, m_any);
                end
            end
            $display("test_random segment %0d: 100 cycles, %0d new errors", seg, errors - seg_err);
        end
        rst = 1'b0;
        bus_if.EVT_ACK = '0;
        bus_if.BTN_IN  = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.BTN_IN  = '0;
        bus_if.EVT_ACK = '0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_ack_race();
        test_reset_mid();
        test_autorepeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
